// File: rtl/router_input_port_if.sv
// router_input_port_if: link bundle between upstream/arbiter side and the router input port.
//   si, di      upstream send strobe and packet
//   ri          ready to upstream
//   req, gnt    one-hot route request [0]=N [1]=S [2]=E [3]=W [4]=PE and its grant
//   dout        hop-updated packet to crossbar, qualified by the dout_valid pulse
//   vc_full     per-VC buffer occupancy
interface router_input_port_if #(parameter int PACKET_WIDTH = 64) ();
  logic                    si;
  logic                    ri;
  logic [PACKET_WIDTH-1:0] di;
  logic [4:0]              req;
  logic                    gnt;
  logic [PACKET_WIDTH-1:0] dout;
  logic                    dout_valid;
  logic [1:0]              vc_full;
  modport master (output si, di, gnt, input ri, req, dout, dout_valid, vc_full);
  modport slave  (input si, di, gnt, output ri, req, dout, dout_valid, vc_full);
endinterface

// File: rtl/router_input_port.sv
// router_input_port: two-VC router input channel with XY route request and hop update.
//   clk       clock, all state on posedge
//   reset     asynchronous active-low reset
//   polarity  router polarity; picks which VC faces upstream (ext) and which faces the crossbar (int)
//   bus       slave side of router_input_port_if (upstream handshake, route request/grant, output packet)
module router_input_port #(
  parameter int PACKET_WIDTH = 64,
  parameter int HOP_WIDTH    = 4
) (
  input logic               clk,
  input logic               reset,
  input logic               polarity,
  router_input_port_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ROUTE, REQ} state_t;
  localparam int HX = 8;
  localparam int HY = 8 + HOP_WIDTH;
  state_t                  state, state_next;
  logic [PACKET_WIDTH-1:0] vc_buf [2];
  logic [PACKET_WIDTH-1:0] sel, upd;
  logic [HOP_WIDTH-1:0]    hop_x, hop_y;
  logic [1:0]              vc_full;
  logic [4:0]              route, target;
  logic                    ext_vc, int_vc, cur_vc, wr, grant;
  assign ext_vc      = ~polarity;
  assign int_vc      = polarity;
  assign bus.ri      = reset & ~vc_full[ext_vc];
  assign bus.vc_full = vc_full;
  assign wr          = bus.si & bus.ri;
  // The request is only visible while the owning VC is on the crossbar side.
  assign bus.req     = (state == REQ && cur_vc == int_vc) ? target : 5'b0;
  assign grant       = bus.gnt & |bus.req;
  assign sel         = vc_buf[cur_vc];
  assign hop_x       = sel[HX +: HOP_WIDTH];
  assign hop_y       = sel[HY +: HOP_WIDTH];
  // X first, then Y; a zero hop count never selects its dimension, so no underflow.
  assign route = hop_x != '0 ? (sel[1] ? 5'b01000 : 5'b00100) :
                 hop_y != '0 ? (sel[2] ? 5'b00010 : 5'b00001) : 5'b10000;
  always_comb begin
    upd = sel;
    if (target[2] | target[3]) upd[HX +: HOP_WIDTH] = hop_x - HOP_WIDTH'(1);
    if (target[0] | target[1]) upd[HY +: HOP_WIDTH] = hop_y - HOP_WIDTH'(1);
  end
  always_comb begin
    state_next = state;
    state_next = state == IDLE  ? (vc_full[int_vc] ? ROUTE : IDLE) :
                 state == ROUTE ? REQ : (grant ? IDLE : REQ);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_next;
  // Upstream write and grant always touch different VCs, so both may land on one edge.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      vc_buf[0]      <= '0;
      vc_buf[1]      <= '0;
      vc_full        <= 2'b00;
      cur_vc         <= 1'b0;
      target         <= 5'b0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
    end else begin
      bus.dout_valid <= grant;
      if (wr) begin
        vc_buf[ext_vc]  <= bus.di;
        vc_full[ext_vc] <= 1'b1;
      end
      if (state == IDLE && vc_full[int_vc]) cur_vc <= int_vc;
      if (state == ROUTE) target <= route;
      if (grant) begin
        bus.dout        <= upd;
        vc_full[cur_vc] <= 1'b0;
      end
    end
endmodule

// File: tb/tb_router_input_port.sv
// tb_router_input_port: directed self-checking bench for router_input_port.
module tb_router_input_port;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic polarity = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  router_input_port_if #(.PACKET_WIDTH(64)) bus ();
  router_input_port #(.PACKET_WIDTH(64), .HOP_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .polarity(polarity), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Polarity toggles just after each edge; outputs are sampled 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #1 polarity = ~polarity;
    #1;
  endtask
  function automatic logic [63:0] mk(input logic dx, input logic dy, input logic [3:0] hx, input logic [3:0] hy);
    logic [63:0] p;
    p        = 64'hDEAD_BEEF_CAFE_0000;
    p[15:12] = hy;
    p[11:8]  = hx;
    p[7:3]   = 5'h15;
    p[2]     = dy;
    p[1]     = dx;
    p[0]     = 1'b0;
    return p;
  endfunction
  task automatic wait_pol(input logic v);
    for (int n = 0; n < 3 && polarity !== v; n++) tick();
  endtask
  task automatic wait_req();
    for (int n = 0; n < 10 && bus.req == 5'b0; n++) tick();
  endtask
  task automatic do_pkt(input string tag, input logic [63:0] pkt, input logic [4:0] exp_req, input logic [63:0] exp_dout);
    wait_pol(1'b1);
    bus.si = 1'b1;
    bus.di = pkt;
    tick();
    bus.si = 1'b0;
    check({tag, "_full"}, 64'(bus.vc_full), 64'(2'b01));
    wait_req();
    check({tag, "_req"}, 64'(bus.req), 64'(exp_req));
    check({tag, "_req_phase"}, 64'(polarity), 64'(1'b0));
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0;
    check({tag, "_valid"}, 64'(bus.dout_valid), 64'(1'b1));
    check({tag, "_dout"}, bus.dout, exp_dout);
    check({tag, "_freed"}, 64'(bus.vc_full), 64'(2'b00));
    tick();
    check({tag, "_pulse"}, 64'(bus.dout_valid), 64'(1'b0));
    check({tag, "_hold"}, bus.dout, exp_dout);
  endtask
  initial begin
    bus.si  = 1'b0;
    bus.di  = '0;
    bus.gnt = 1'b0;
    repeat (3) tick();
    check("rst_ri", 64'(bus.ri), 64'(1'b0));
    check("rst_req", 64'(bus.req), 64'(5'b0));
    check("rst_dout", bus.dout, 64'h0);
    check("rst_valid", 64'(bus.dout_valid), 64'(1'b0));
    check("rst_full", 64'(bus.vc_full), 64'(2'b00));
    reset = 1'b1;
    #1;
    check("rel_ri", 64'(bus.ri), 64'(1'b1));
    tick();
    do_pkt("east", mk(0, 0, 3, 0), 5'b00100, mk(0, 0, 2, 0));
    do_pkt("west", mk(1, 1, 1, 5), 5'b01000, mk(1, 1, 0, 5));
    do_pkt("south", mk(0, 1, 0, 2), 5'b00010, mk(0, 1, 0, 1));
    do_pkt("north", mk(1, 0, 0, 1), 5'b00001, mk(1, 0, 0, 0));
    do_pkt("pe", mk(1, 1, 0, 0), 5'b10000, mk(1, 1, 0, 0));
    do_pkt("xwrap", mk(0, 0, 15, 0), 5'b00100, mk(0, 0, 14, 0));
    // Both VCs full: VC0 gets an east packet, VC1 a north packet.
    wait_pol(1'b1);
    bus.si = 1'b1;
    bus.di = mk(0, 0, 2, 0);
    tick();
    bus.di = mk(0, 0, 0, 3);
    tick();
    bus.si = 1'b0;
    check("both_full", 64'(bus.vc_full), 64'(2'b11));
    wait_req();
    for (int i = 0; i < 10; i++) begin
      check("stall_ri", 64'(bus.ri), 64'(1'b0));
      check("stall_req", 64'(bus.req), polarity ? 64'(5'b0) : 64'(5'b00100));
      tick();
    end
    wait_pol(1'b0);
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0;
    check("both_dout", bus.dout, mk(0, 0, 1, 0));
    check("both_left", 64'(bus.vc_full), 64'(2'b10));
    // Upstream write into VC0 on the same edge that grants VC1.
    wait_req();
    check("same_req", 64'(bus.req), 64'(5'b00001));
    check("same_ri", 64'(bus.ri), 64'(1'b1));
    bus.si  = 1'b1;
    bus.di  = mk(1, 0, 4, 0);
    bus.gnt = 1'b1;
    tick();
    bus.si  = 1'b0;
    bus.gnt = 1'b0;
    check("same_full", 64'(bus.vc_full), 64'(2'b01));
    check("same_valid", 64'(bus.dout_valid), 64'(1'b1));
    check("same_dout", bus.dout, mk(0, 0, 0, 2));
    wait_req();
    check("same_next_req", 64'(bus.req), 64'(5'b01000));
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0;
    check("same_next_dout", bus.dout, mk(1, 0, 3, 0));
    check("same_next_full", 64'(bus.vc_full), 64'(2'b00));
    // Reset during REQ drops the pending packet.
    wait_pol(1'b1);
    bus.si = 1'b1;
    bus.di = mk(0, 1, 0, 7);
    tick();
    bus.si = 1'b0;
    wait_req();
    check("mid_req", 64'(bus.req), 64'(5'b00010));
    reset = 1'b0;
    #1;
    check("mid_req_off", 64'(bus.req), 64'(5'b0));
    check("mid_full", 64'(bus.vc_full), 64'(2'b00));
    check("mid_ri", 64'(bus.ri), 64'(1'b0));
    check("mid_dout", bus.dout, 64'h0);
    tick();
    check("mid_valid", 64'(bus.dout_valid), 64'(1'b0));
    reset = 1'b1;
    repeat (4) begin
      tick();
      check("post_req", 64'(bus.req), 64'(5'b0));
      check("post_valid", 64'(bus.dout_valid), 64'(1'b0));
    end
    check("post_full", 64'(bus.vc_full), 64'(2'b00));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
